axis_framer_master: RTL and testbench
=====================================

Name: axis_framer_master

Overview:
- Parameterised successor to the single-marker stream master.
- Buffers payload words in an internal FWFT FIFO and emits framed packets on a valid/ready stream.
- Each packet is a programmable-length payload with an optional multi-beat marker as header, trailer, or both.
- Provides correct backpressure hold, a last beat, a marker-beat flag, and status outputs. Sits between a producer and a stream slave such as an interconnect port.

Parameters:
- DATA_W, 8: stream/FIFO word width in bits.
- MARK_W, 16: marker width in bits; must be an integer multiple of DATA_W (MB = MARK_W/DATA_W beats).
- FIFO_DEPTH, 16: payload FIFO depth in words; power of two, ≥2.
- MAX_PKT, 256: maximum payload beats per packet; LEN_W = $clog2(MAX_PKT)+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- write  in  1  push buffer_in into the FIFO.
- buffer_in  in  DATA_W  payload word.
- full  out  1  FIFO full.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  one-cycle pulse: write while full (word dropped).
- pkt_len  in  LEN_W  payload beats per packet.
- marker_mode  in  2  00 none, 01 trailer, 10 header, 11 header+trailer.
- marker_val  in  MARK_W  marker pattern.
- valid  out  1  stream valid.
- ready  in  1  stream ready.
- data_out  out  DATA_W  stream data.
- last  out  1  final beat of packet.
- marker  out  1  current beat is a marker beat.
- busy  out  1  packet in progress (state ≠ IDLE).
- pkt_done  out  1  one-cycle pulse after the handshake of the last beat.

Behaviour:
- Reset (async assert, sync deassert expected): FIFO empty, state IDLE, all counters 0; valid, last, marker, busy, pkt_done, overflow, full = 0; level = 0; data_out = 0.
- FIFO:
  - FWFT; write is accepted when !full.
  - Write while full: word dropped, overflow pulses the next cycle.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Handshake = valid & ready. Once valid rises, data_out/last/marker stay stable until the handshake. valid never drops without a handshake, except on reset.
- Per-packet latch: in IDLE, when level ≠ 0, latch pkt_len, marker_mode and marker_val into internal registers.
  - Effective length L = 1 if pkt_len = 0; L = MAX_PKT if pkt_len > MAX_PKT; otherwise L = pkt_len.
  - Input changes mid-packet have no effect.
- FSM:
  - IDLE → HEAD if mode[1], else PAYLOAD, on the cycle level ≠ 0. valid is first asserted the cycle after the latch (1-cycle start latency).
  - HEAD: MB beats of marker_val, most-significant slice first; marker = 1; valid = 1 unconditionally. After the MB-th handshake → PAYLOAD.
  - PAYLOAD: data_out = FIFO head, valid = (level ≠ 0), marker = 0. Each handshake pops one word. After the L-th handshake → TAIL if mode[0], else IDLE.
  - TAIL: MB beats as in HEAD. After the MB-th handshake → IDLE.
- last = 1 on the final beat only: the last TAIL beat if mode[0], else the L-th payload beat. With a header only, last is never set on a header beat.
- pkt_done pulses the cycle after the last-beat handshake.
- Back-to-back packets: return to IDLE costs 1 bubble cycle minimum.
- Payload underflow mid-packet: valid deasserts, state holds, and the packet resumes when data arrives.
- Beat counter width is LEN_W; marker slice counter is $clog2(MB)+1. Neither counter wraps within a packet.
- Reset mid-packet: packet is abandoned, FIFO contents are discarded, and no pkt_done is issued.

Test Plan:
- Defaults, mode 00, pkt_len 3, write 0x11,0x22,0x33, ready = 1 → beats 11,22,33; last on 33; marker = 0 throughout; pkt_done one cycle later.
- Mode 11, marker_val 0xA55A, pkt_len 2, data 0x01,0x02 → beats A5,5A,01,02,A5,5A; marker = 1,1,0,0,1,1; last only on the final 5A.
- Mode 10, pkt_len 2, ready low for 5 cycles on the first header beat → valid held, data_out stays A5 and stable; sequence completes A5,5A,d0,d1 with last on d1.
- Write 17 words at FIFO_DEPTH 16 with ready = 0 → full = 1 after the 16th write, overflow pulses once, level = 16; drain yields the first 16 words in order.
- Mode 01, pkt_len 0 → 1 payload beat then 2 marker beats; pkt_len 300 clamped to 256 beats, with last on the final marker beat.
- Assert reset mid-payload on the 2nd beat of a 4-beat packet → valid, busy and level are 0 immediately (async); after release, new writes start a fresh packet from its header.

Source files
------------

// File: rtl/axis_framer_master.sv
// Framed stream master: payload words buffered in a FWFT FIFO, emitted as
// packets of programmable length with an optional multi-beat header/trailer marker.
module axis_framer_master #(
  parameter int DATA_W     = 8,
  parameter int MARK_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_PKT    = 256,
  localparam int LEN_W     = $clog2(MAX_PKT) + 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] buffer_in,
  output logic              full,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [1:0]        marker_mode,
  input  logic [MARK_W-1:0] marker_val,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              last,
  output logic              marker,
  output logic              busy,
  output logic              pkt_done
);

  localparam int MB    = MARK_W / DATA_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SLC_W = $clog2(MB) + 1;

  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, TAIL} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              empty, push, pop, hs;

  logic [LEN_W-1:0]  len_r, eff_len, beat_cnt;
  logic [1:0]        mode_r;
  logic [MARK_W-1:0] mark_r;
  logic [SLC_W-1:0]  slc_cnt;
  logic              slc_last, beat_last;
  logic [DATA_W-1:0] mslice;

  // ---------------- payload FIFO ----------------
  assign full  = (count == LVL_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign hs    = valid & ready;
  assign push  = write & ~full;
  assign pop   = (state == PAYLOAD) & hs;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= buffer_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= write & full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- per-packet configuration ----------------
  always_comb begin
    eff_len = pkt_len;
    if (pkt_len == '0)                     eff_len = LEN_W'(1);
    else if (pkt_len > LEN_W'(MAX_PKT))    eff_len = LEN_W'(MAX_PKT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r  <= '0;
      mode_r <= '0;
      mark_r <= '0;
    end else if (state == IDLE && !empty) begin
      len_r  <= eff_len;
      mode_r <= marker_mode;
      mark_r <= marker_val;
    end
  end

  // ---------------- beat / slice counters ----------------
  assign slc_last  = (slc_cnt == SLC_W'(MB - 1));
  assign beat_last = (beat_cnt == len_r - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      slc_cnt  <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
      slc_cnt  <= '0;
    end else if (hs) begin
      case (state)
        HEAD, TAIL: slc_cnt  <= slc_last ? '0 : slc_cnt + 1'b1;
        PAYLOAD:    beat_cnt <= beat_cnt + 1'b1;
        default:    ;
      endcase
    end
  end

  // Marker slices go out most-significant first.
  always_comb begin
    mslice = '0;
    for (int i = 0; i < MB; i++)
      if (slc_cnt == SLC_W'(i)) mslice = mark_r[(MB-1-i)*DATA_W +: DATA_W];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    marker    = 1'b0;
    last      = 1'b0;
    data_out  = '0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = marker_mode[1] ? HEAD : PAYLOAD;
      end
      HEAD: begin
        valid    = 1'b1;
        marker   = 1'b1;
        data_out = mslice;
        if (hs && slc_last) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        // Outputs are pure functions of state and FIFO head, so they hold
        // steady until the handshake that pops the head.
        valid    = !empty;
        data_out = empty ? '0 : mem[rd_ptr];
        last     = !mode_r[0] && beat_last;
        if (hs && beat_last) state_nxt = mode_r[0] ? TAIL : IDLE;
      end
      TAIL: begin
        valid    = 1'b1;
        marker   = 1'b1;
        data_out = mslice;
        last     = slc_last;
        if (hs && slc_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_done <= 1'b0;
    else       pkt_done <= hs & last;
  end

endmodule

// File: tb/tb_axis_framer_master.sv
// Scoreboard bench for axis_framer_master: stimulus pushes expected beats,
// a negedge monitor compares every handshake and every pkt_done pulse.
module tb_axis_framer_master;

  localparam int DATA_W = 8, MARK_W = 16, FIFO_DEPTH = 16, MAX_PKT = 256;
  localparam int LEN_W = $clog2(MAX_PKT) + 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 0, reset = 1, write = 0, ready = 0;
  logic [DATA_W-1:0] buffer_in = '0;
  logic              full, overflow, valid, last, marker, busy, pkt_done;
  logic [LVL_W-1:0]  level;
  logic [LEN_W-1:0]  pkt_len = '0;
  logic [1:0]        marker_mode = '0;
  logic [MARK_W-1:0] marker_val = '0;
  logic [DATA_W-1:0] data_out;

  axis_framer_master #(.DATA_W(DATA_W), .MARK_W(MARK_W), .FIFO_DEPTH(FIFO_DEPTH),
                       .MAX_PKT(MAX_PKT)) dut (
    .clk(clk), .reset(reset), .write(write), .buffer_in(buffer_in), .full(full),
    .level(level), .overflow(overflow), .pkt_len(pkt_len), .marker_mode(marker_mode),
    .marker_val(marker_val), .valid(valid), .ready(ready), .data_out(data_out),
    .last(last), .marker(marker), .busy(busy), .pkt_done(pkt_done));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; logic m; } beat_t;
  beat_t exp_q[$];
  int n_vec = 0, n_err = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_b(input logic [7:0] d, input logic l, input logic m);
    beat_t b;
    b.d = d; b.l = l; b.m = m;
    exp_q.push_back(b);
  endtask

  task automatic push_mk(input logic [15:0] mv, input logic is_end);
    push_b(mv[15:8], 1'b0, 1'b1);
    push_b(mv[7:0], is_end, 1'b1);
  endtask

  task automatic wr(input logic [7:0] w);
    buffer_in = w;
    write = 1;
    @(posedge clk); #1;
    write = 0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!valid && t < 200) begin @(posedge clk); #1; t++; end
    if (!valid) chk("valid_timeout", 32'(valid), 32'd1);
  endtask

  // Exactly one handshake, then ready drops again.
  task automatic take1();
    wait_valid();
    ready = 1;
    @(posedge clk); #1;
    ready = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every handshake against the queue and checks pkt_done
  // fires exactly one cycle after a last-beat handshake.
  initial begin
    logic done_exp = 0;
    beat_t b;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_exp = 0;
      end else begin
        if (done_exp || pkt_done) chk("pkt_done", 32'(pkt_done), 32'(done_exp));
        if (pkt_done) n_done++;
        done_exp = valid && ready && last;
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(data_out), 32'hFFFF_FFFF);
          end else begin
            b = exp_q.pop_front();
            chk("data", 32'(data_out), 32'(b.d));
            chk("last", 32'(last), 32'(b.l));
            chk("marker", 32'(marker), 32'(b.m));
          end
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_flags", {28'd0, last, marker, pkt_done, overflow}, 0);
    chk("rst_data", 32'(data_out), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;

    // 1: no marker, 3 payload beats
    marker_mode = 2'b00; pkt_len = 3; ready = 1;
    push_b(8'h11, 0, 0); push_b(8'h22, 0, 0); push_b(8'h33, 1, 0);
    wr(8'h11); wr(8'h22); wr(8'h33);
    drain();

    // 2: header + trailer
    marker_mode = 2'b11; marker_val = 16'hA55A; pkt_len = 2;
    push_mk(16'hA55A, 0); push_b(8'h01, 0, 0); push_b(8'h02, 0, 0); push_mk(16'hA55A, 1);
    wr(8'h01); wr(8'h02);
    drain();

    // 3: header only, stall on first header beat
    ready = 0; marker_mode = 2'b10; pkt_len = 2;
    push_mk(16'hA55A, 0); push_b(8'hC3, 0, 0); push_b(8'h3C, 1, 0);
    wr(8'hC3); wr(8'h3C);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(valid), 1);
      chk("stall_data", 32'(data_out), 32'hA5);
    end
    @(posedge clk); #1 ready = 1;
    drain();

    // 4: fill FIFO past full with ready low
    ready = 0; marker_mode = 2'b00; pkt_len = 16;
    for (int i = 0; i < 16; i++) push_b(8'(8'h40 + i), i == 15, 0);
    for (int i = 0; i < 17; i++) begin
      wr(8'(8'h40 + i));
      if (i == 15) begin
        chk("full_16", 32'(full), 1);
        chk("ovf_16", 32'(overflow), 0);
      end
    end
    chk("ovf_17", 32'(overflow), 1);
    chk("level_full", 32'(level), 16);
    @(posedge clk); #1;
    chk("ovf_once", 32'(overflow), 0);
    ready = 1;
    drain();

    // 5a: trailer, pkt_len 0 -> 1 payload beat
    marker_mode = 2'b01; marker_val = 16'hBEEF; pkt_len = 0;
    push_b(8'h99, 0, 0); push_mk(16'hBEEF, 1);
    wr(8'h99);
    drain();

    // 5b: pkt_len 300 clamps to 256 payload beats
    pkt_len = 300;
    for (int i = 0; i < 256; i++) push_b(8'(i), 0, 0);
    push_mk(16'hBEEF, 1);
    for (int i = 0; i < 256; i++) begin
      int t = 0;
      while (full && t < 100) begin @(posedge clk); #1; t++; end
      wr(8'(i));
    end
    drain();

    // 6: reset in the middle of the payload
    marker_mode = 2'b10; marker_val = 16'h5AA5; pkt_len = 4; ready = 0;
    push_mk(16'h5AA5, 0); push_b(8'h41, 0, 0);
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44);
    take1(); take1(); take1();
    chk("pre_rst_pending", 32'(exp_q.size()), 0);
    reset = 1;
    #1;
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_level", 32'(level), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    marker_mode = 2'b11; marker_val = 16'h1234; pkt_len = 2; ready = 1;
    push_mk(16'h1234, 0); push_b(8'h77, 0, 0); push_b(8'h88, 0, 0); push_mk(16'h1234, 1);
    wr(8'h77); wr(8'h88);
    drain();

    chk("done_count", 32'(n_done), 7);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
